// File: rtl/fft_bfly_scheduler.sv
// fft_bfly_scheduler: in-place radix-2 DIT FFT sequencer (read/twiddle/write-back addresses for one butterfly).
// Optional FFT_SCHED_HOLD_EN adds a `hold` input that stalls issue.
module fft_bfly_scheduler #(
   parameter int LOG2N    = 3,
   parameter int BFLY_LAT = 2,
   parameter int MEM_LAT  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef FFT_SCHED_HOLD_EN
   input  logic             hold,
`endif
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);
   localparam int PIPE = MEM_LAT + BFLY_LAT;
   localparam int KW = LOG2N - 1;
   localparam logic [KW-1:0] K_LAST = '1;
   localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
   localparam logic [PIPE-1:0] REST_M = {PIPE{1'b1}} >> 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [LOG2N-1:0] s_q, s_d;
   logic             done_q, done_d;
   logic             stall, last_wb;
   logic [PIPE-1:0]  v_q;
   logic [LOG2N-1:0] pa_q [PIPE];
   logic [LOG2N-1:0] pb_q [PIPE];
   logic [LOG2N-1:0] half, pos, grp, a, b;
   logic [KW-1:0]    tw;

`ifdef FFT_SCHED_HOLD_EN
   assign stall = hold;
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      half = LOG2N'(1) << s_q;
      pos  = {1'b0, k_q} & (half - LOG2N'(1));
      grp  = {1'b0, k_q} >> s_q;
      a    = ((grp << s_q) << 1) | pos;
      b    = a + half;
      tw   = pos[KW-1:0] << (LOG2N'(KW) - s_q);
   end

   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign stage     = s_q;
   assign rd_en     = (state_q == ISSUE) && !stall;
   assign rd_addr_a = rd_en ? a : '0;
   assign rd_addr_b = rd_en ? b : '0;
   assign tw_addr   = rd_en ? tw : '0;
   assign wr_en     = v_q[PIPE-1];
   assign wr_addr_a = pa_q[PIPE-1];
   assign wr_addr_b = pb_q[PIPE-1];
   // Stage barrier: the last write-back is the one with nothing younger behind it.
   assign last_wb   = wr_en && !(|(v_q & REST_M));

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      s_d     = s_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: if (start) begin
            state_d = ISSUE;
            k_d     = '0;
            s_d     = '0;
         end
         ISSUE: if (rd_en) begin
            k_d     = (k_q == K_LAST) ? '0 : k_q + KW'(1);
            state_d = (k_q == K_LAST) ? DRAIN : ISSUE;
         end
         DRAIN: if (last_wb) begin
            state_d = (s_q == S_LAST) ? IDLE : ISSUE;
            s_d     = (s_q == S_LAST) ? '0 : s_q + LOG2N'(1);
            done_d  = s_q == S_LAST;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         s_q     <= '0;
         done_q  <= 1'b0;
         v_q     <= '0;
         for (int i = 0; i < PIPE; i++) begin
            pa_q[i] <= '0;
            pb_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         s_q     <= s_d;
         done_q  <= done_d;
         v_q     <= (v_q << 1) | PIPE'(rd_en);
         pa_q[0] <= rd_addr_a;
         pb_q[0] <= rd_addr_b;
         for (int i = 1; i < PIPE; i++) begin
            pa_q[i] <= pa_q[i-1];
            pb_q[i] <= pb_q[i-1];
         end
      end
   end
endmodule
